ov_addsub_acc: RTL and testbench

Parametrised, registered signed adder/subtractor with two's-complement overflow detection, an optional saturating mode, and an accumulate mode. It is the next generation of our single-bit-wide overflow detector: the same a/b/s (subtract) operand model, generalised to WIDTH bits, pipelined one stage, with per-result and sticky overflow flags. It sits between operand sources such as switches or counters and display or downstream arithmetic logic.

---
 rtl/ov_pkg.sv | 17 +
 rtl/ov_addsub_core.sv | 39 +++
 rtl/ov_addsub_acc.sv | 93 +++++++++
 tb/tb_ov_addsub_acc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ov_pkg.sv
// Shared constants for the overflow-aware adder/subtractor family:
// operation encoding of s and MAX/MIN helpers for a given width.
package ov_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widths up to 64 bits; callers truncate to their own WIDTH.
    function automatic logic [63:0] max_val(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_val(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ov_addsub_core.sv
// Combinational signed X +/- B in WIDTH+1 bits with overflow detect and
// optional clamping to MAX/MIN.
module ov_addsub_core
    import ov_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH:0]   ext,
    output logic             ov_n,
    output logic [WIDTH-1:0] sat_result
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(min_val(WIDTH));

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] b_ext;

    always_comb begin
        x_ext = {x[WIDTH-1], x};
        b_ext = {b[WIDTH-1], b};
        // One extra bit keeps X - MIN representable before the overflow test.
        if (s == OP_SUB) begin
            ext = x_ext - b_ext;
        end else begin
            ext = x_ext + b_ext;
        end
        ov_n       = ext[WIDTH] ^ ext[WIDTH-1];
        sat_result = ext[WIDTH-1:0];
        if ((SATURATE != 0) && ov_n) begin
            sat_result = ext[WIDTH] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/ov_addsub_acc.sv
// Registered signed add/subtract with per-result and sticky overflow flags,
// optional saturation and a running accumulator operand.
module ov_addsub_acc
    import ov_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic             ov_clr,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             ov,
    output logic             ov_sticky
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ov_q, ov_d;
    logic             ov_sticky_q, ov_sticky_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] x_op;
    logic [WIDTH:0]   ext_unused;
    logic             ov_n;
    logic [WIDTH-1:0] sat_result;

    // A same-cycle clear overrides the accumulator as operand.
    always_comb begin
        x_op = a;
        if (acc_mode) begin
            x_op = acc_clr ? '0 : acc_q;
        end
    end

    ov_addsub_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .x          (x_op),
        .b          (b),
        .s          (s),
        .ext        (ext_unused),
        .ov_n       (ov_n),
        .sat_result (sat_result)
    );

    always_comb begin
        acc_d       = acc_q;
        result_d    = result_q;
        ov_d        = ov_q;
        out_valid_d = in_valid;
        ov_sticky_d = (ov_sticky_q & ~ov_clr) | (in_valid & ov_n);
        if (in_valid) begin
            result_d = sat_result;
            ov_d     = ov_n;
        end
        if (in_valid && acc_mode) begin
            acc_d = sat_result;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            result_q    <= '0;
            ov_q        <= 1'b0;
            ov_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            result_q    <= result_d;
            ov_q        <= ov_d;
            ov_sticky_q <= ov_sticky_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign ov        = ov_q;
    assign ov_sticky = ov_sticky_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ov_addsub_acc.sv
// Bench for ov_addsub_acc: wrapping and saturating instances share stimulus
// and are compared against an integer-arithmetic reference model.
module tb_ov_addsub_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, s, acc_mode, acc_clr, ov_clr;
    logic [7:0] a, b;
    logic [7:0] res0, res1;
    logic       vld0, vld1, ov0, ov1, st0, st1;

    ov_addsub_acc #(.WIDTH(8), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .s(s),
        .acc_mode(acc_mode), .acc_clr(acc_clr), .ov_clr(ov_clr),
        .result(res0), .out_valid(vld0), .ov(ov0), .ov_sticky(st0)
    );

    ov_addsub_acc #(.WIDTH(8), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .s(s),
        .acc_mode(acc_mode), .acc_clr(acc_clr), .ov_clr(ov_clr),
        .result(res1), .out_valid(vld1), .ov(ov1), .ov_sticky(st1)
    );

    int total = 0;
    int bad   = 0;

    // Reference state, index 0 = wrapping, 1 = saturating.
    logic [7:0] m_res [2];
    logic       m_ov  [2];
    logic       m_st  [2];
    logic [7:0] m_acc [2];
    logic       m_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int x, r;
        logic ovn;
        logic [7:0] rr;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_res[k] = 8'd0; m_ov[k] = 1'b0; m_st[k] = 1'b0; m_acc[k] = 8'd0;
            end else begin
                if (acc_mode) x = acc_clr ? 0 : int'($signed(m_acc[k]));
                else          x = int'($signed(a));
                r   = s ? x - int'($signed(b)) : x + int'($signed(b));
                ovn = (r > 127) || (r < -128);
                if (k == 1 && r > 127)       rr = 8'h7f;
                else if (k == 1 && r < -128) rr = 8'h80;
                else                         rr = 8'(r);
                if (in_valid) begin
                    m_res[k] = rr;
                    m_ov[k]  = ovn;
                end
                if (in_valid && acc_mode) m_acc[k] = rr;
                else if (acc_clr)         m_acc[k] = 8'd0;
                m_st[k] = (m_st[k] & ~ov_clr) | (in_valid & ovn);
            end
        end
        m_vld = rst ? 1'b0 : in_valid;
    endtask

    task automatic op(input logic r_i, input logic iv, input logic [7:0] ai, input logic [7:0] bi,
                      input logic si, input logic am, input logic ac, input logic oc);
        rst = r_i; in_valid = iv; a = ai; b = bi; s = si;
        acc_mode = am; acc_clr = ac; ov_clr = oc;
        @(posedge clk);
        model_step();
        #1;
        chk("vld_wrap", vld0, m_vld);
        chk("res_wrap", res0, m_res[0]);
        chk("ov_wrap",  ov0,  m_ov[0]);
        chk("st_wrap",  st0,  m_st[0]);
        chk("vld_sat",  vld1, m_vld);
        chk("res_sat",  res1, m_res[1]);
        chk("ov_sat",   ov1,  m_ov[1]);
        chk("st_sat",   st1,  m_st[1]);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h7f;
            1: return 8'h80;
            2: return 8'h00;
            3: return 8'hff;
            4: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_res[k] = 8'd0; m_ov[k] = 1'b0; m_st[k] = 1'b0; m_acc[k] = 8'd0;
        end
        m_vld = 1'b0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; s = 1'b0;
        acc_mode = 1'b0; acc_clr = 1'b0; ov_clr = 1'b0;

        op(1, 1, 8'd55, 8'd66, 0, 1, 0, 0);
        op(1, 0, 8'd0, 8'd0, 0, 0, 0, 0);
        chk("rst_res", res0, 8'd0);
        chk("rst_vld", vld0, 1'b0);

        // Wrap at +127 -> -128.
        op(0, 1, 8'd100, 8'd27, 0, 0, 0, 0);
        chk("tp1_res", res0, 8'd127);
        chk("tp1_ov", ov0, 1'b0);
        op(0, 1, 8'd100, 8'd28, 0, 0, 0, 0);
        chk("tp1b_res", res0, 8'h80);
        chk("tp1b_ov", ov0, 1'b1);
        chk("tp1b_st", st0, 1'b1);
        chk("tp1b_satres", res1, 8'h7f);

        // Saturation at both ends, including subtracting MIN.
        op(0, 1, 8'h80, 8'd1, 1, 0, 0, 0);
        chk("tp2_res", res1, 8'h80);
        chk("tp2_ov", ov1, 1'b1);
        op(0, 1, 8'd0, 8'h80, 1, 0, 0, 0);
        chk("tp2b_res", res1, 8'h7f);
        chk("tp2b_ov", ov1, 1'b1);

        // Sticky clear racing a new overflow, then a clean clear.
        op(0, 1, 8'd100, 8'd28, 0, 0, 0, 1);
        chk("tp4_st", st0, 1'b1);
        op(0, 1, 8'd1, 8'd1, 0, 0, 0, 1);
        chk("tp4b_st", st0, 1'b0);

        // Accumulate chain 50, 100, -106.
        op(0, 0, 8'd0, 8'd0, 0, 0, 1, 0);
        chk("tp3_clr_vld", vld0, 1'b0);
        op(0, 1, 8'd9, 8'd50, 0, 1, 0, 0);
        chk("tp3_r1", res0, 8'd50);
        op(0, 1, 8'd9, 8'd50, 0, 1, 0, 0);
        chk("tp3_r2", res0, 8'd100);
        chk("tp3_st2", st0, 1'b0);
        op(0, 1, 8'd9, 8'd50, 0, 1, 0, 0);
        chk("tp3_r3", res0, 8'h96);
        chk("tp3_ov3", ov0, 1'b1);
        chk("tp3_st3", st0, 1'b1);

        // acc=40, then clear + subtract 5 gives -5; idle cycles hold result.
        op(0, 0, 8'd0, 8'd0, 0, 0, 1, 1);
        op(0, 1, 8'd0, 8'd40, 0, 1, 0, 0);
        op(0, 1, 8'd77, 8'd5, 1, 1, 1, 0);
        chk("tp5_res", res0, 8'hfb);
        op(0, 0, 8'd1, 8'd1, 0, 0, 0, 0);
        chk("tp5_idle_vld", vld0, 1'b0);
        chk("tp5_idle_res", res0, 8'hfb);
        op(0, 0, 8'd2, 8'd2, 0, 1, 0, 0);
        op(0, 1, 8'd0, 8'd0, 0, 1, 0, 0);
        chk("tp5_acc", res0, 8'hfb);

        // Mid-stream reset with acc=90.
        op(0, 0, 8'd0, 8'd0, 0, 0, 1, 0);
        op(0, 1, 8'd0, 8'd90, 0, 1, 0, 0);
        op(0, 1, 8'd0, 8'd1, 0, 1, 0, 0);
        op(1, 1, 8'd0, 8'd1, 0, 1, 0, 0);
        chk("tp6_rst_res", res0, 8'd0);
        op(0, 0, 8'd0, 8'd0, 0, 0, 0, 0);
        chk("tp6_post_res", res0, 8'd0);
        chk("tp6_post_vld", vld0, 1'b0);
        op(0, 1, 8'd3, 8'd4, 0, 0, 0, 0);
        chk("tp6_new", res0, 8'd7);
        op(0, 1, 8'd3, 8'd0, 0, 1, 0, 0);
        chk("tp6_acc0", res0, 8'd0);

        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), pick(), pick(),
               1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
